// File: rtl/instr_fetch.sv
// Fetch back half: synchronous instruction-memory read with a registered instruction to decode, run-state FSM, HALT detect, fetch counter.
// Latency: Instr/InstrValid/FetchAddr are valid one cycle after the ProgCtr that produced them.
// Backpressure: Stall holds all fetch outputs and the counter; Flush squashes the fetch into a NOP and wins over Stall.
module instr_fetch #(
  parameter int            IW      = 9,
  parameter int            AW      = 10,
  parameter logic [IW-1:0] HALT_OP = 9'h1FF,
  parameter logic [IW-1:0] NOP_OP  = 9'h000
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          Start,
  input  logic [9:0]    ProgCtr,
  input  logic          Stall,
  input  logic          Flush,
  input  logic          LoadEn,
  input  logic [AW-1:0] LoadAddr,
  input  logic [IW-1:0] LoadData,
  output logic [IW-1:0] Instr,
  output logic          InstrValid,
  output logic [9:0]    FetchAddr,
  output logic          Done,
  output logic          AddrErr,
  output logic [15:0]   FetchCount
);

  localparam int         DEPTH   = 1 << AW;
  // One bit wider than ProgCtr so a full 1024-word memory never reports out of range.
  localparam logic [10:0] DEPTH_W = 11'(DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state;
  logic [IW-1:0] mem [DEPTH];
  logic          startQ;
  logic          outOfRange;
  logic          startRise;
  logic [IW-1:0] rdWord;

  assign outOfRange = ({1'b0, ProgCtr} >= DEPTH_W);
  assign startRise  = Start & ~startQ;
  assign rdWord     = mem[ProgCtr[AW-1:0]];

  // Preload port: memory is only writable while the machine is idle, so no read bypass is needed.
  always_ff @(posedge Clk) begin
    if (!Reset && state == IDLE && LoadEn) begin
      mem[LoadAddr] <= LoadData;
    end
  end

  // Run-state FSM with registered fetch outputs; Flush beats Stall beats a normal fetch.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state      <= IDLE;
      Instr      <= NOP_OP;
      InstrValid <= 1'b0;
      FetchAddr  <= '0;
      Done       <= 1'b0;
      AddrErr    <= 1'b0;
      FetchCount <= '0;
      startQ     <= 1'b0;
    end else begin
      startQ <= Start;
      case (state)
        IDLE: begin
          if (Start) begin
            state <= RUN;
          end
        end
        RUN: begin
          if (Flush) begin
            Instr      <= NOP_OP;
            InstrValid <= 1'b0;
            FetchAddr  <= ProgCtr;
          end else if (!Stall) begin
            FetchAddr  <= ProgCtr;
            InstrValid <= 1'b1;
            if (FetchCount != 16'hFFFF) begin
              FetchCount <= FetchCount + 16'd1;
            end
            if (outOfRange) begin
              // Still a fetch slot from decode's view, so it is valid and counted.
              Instr   <= NOP_OP;
              AddrErr <= 1'b1;
            end else begin
              Instr <= rdWord;
              if (rdWord == HALT_OP) begin
                Done  <= 1'b1;
                state <= DONE;
              end
            end
          end
        end
        DONE: begin
          // HALT word and its address stay visible; only the valid strobe drops.
          InstrValid <= 1'b0;
          if (startRise) begin
            Done  <= 1'b0;
            state <= RUN;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: a full-size (AW=10) and a reduced (AW=8) instance driven in lockstep.
// A behavioural model predicts every output each cycle; directed literal checks pin the model.
module tb_instr_fetch;

  logic       Clk;
  logic       Reset, Start, Stall, Flush, LoadEn;
  logic [9:0] ProgCtr, LoadAddr;
  logic [8:0] LoadData;

  logic [8:0]  instr0, instr8;
  logic        valid0, valid8, done0, done8, err0, err8;
  logic [9:0]  fa0, fa8;
  logic [15:0] cnt0, cnt8;

  int  checks = 0;
  int  errors = 0;
  bit  armed  = 0;

  instr_fetch #(.IW(9), .AW(10)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .ProgCtr(ProgCtr), .Stall(Stall),
    .Flush(Flush), .LoadEn(LoadEn), .LoadAddr(LoadAddr), .LoadData(LoadData),
    .Instr(instr0), .InstrValid(valid0), .FetchAddr(fa0), .Done(done0),
    .AddrErr(err0), .FetchCount(cnt0)
  );

  instr_fetch #(.IW(9), .AW(8)) dut8 (
    .Clk(Clk), .Reset(Reset), .Start(Start), .ProgCtr(ProgCtr), .Stall(Stall),
    .Flush(Flush), .LoadEn(LoadEn), .LoadAddr(LoadAddr[7:0]), .LoadData(LoadData),
    .Instr(instr8), .InstrValid(valid8), .FetchAddr(fa8), .Done(done8),
    .AddrErr(err8), .FetchCount(cnt8)
  );

  initial begin
    Clk = 0;
    forever #5 Clk = ~Clk;
  end

  // Behavioural model: index 0 = 1024-word memory, index 1 = 256-word memory.
  int         mSt [2];          // 0 idle, 1 run, 2 done
  logic [8:0] mInstr [2];
  bit         mValid [2];
  logic [9:0] mAddr [2];
  bit         mDone [2];
  bit         mErr [2];
  int         mCnt [2];
  bit         mPrevStart [2];
  logic [8:0] mMem [2][1024];

  always @(posedge Clk) begin
    for (int i = 0; i < 2; i++) begin
      int depth;
      logic [8:0] w;
      depth = (i == 0) ? 1024 : 256;
      if (Reset) begin
        mSt[i] = 0; mInstr[i] = 9'h000; mValid[i] = 0; mAddr[i] = 0;
        mDone[i] = 0; mErr[i] = 0; mCnt[i] = 0; mPrevStart[i] = 0;
      end else begin
        if (mSt[i] == 0) begin
          if (LoadEn) mMem[i][int'(LoadAddr) % depth] = LoadData;
          if (Start) mSt[i] = 1;
        end else if (mSt[i] == 1) begin
          if (Flush) begin
            mInstr[i] = 9'h000; mValid[i] = 0; mAddr[i] = ProgCtr;
          end else if (!Stall) begin
            mAddr[i] = ProgCtr; mValid[i] = 1;
            if (mCnt[i] < 65535) mCnt[i] = mCnt[i] + 1;
            if (int'(ProgCtr) >= depth) begin
              mInstr[i] = 9'h000; mErr[i] = 1;
            end else begin
              w = mMem[i][int'(ProgCtr)];
              mInstr[i] = w;
              if (w == 9'h1FF) begin mDone[i] = 1; mSt[i] = 2; end
            end
          end
        end else begin
          mValid[i] = 0;
          if (Start && !mPrevStart[i]) begin mSt[i] = 1; mDone[i] = 0; end
        end
        mPrevStart[i] = Start;
      end
    end
  end

  task automatic cmpDut(string nm, int i, logic [8:0] ins, logic v, logic [9:0] a,
                        logic d, logic e, logic [15:0] c);
    checks++;
    if ({ins, v, a, d, e, c} !== {mInstr[i], mValid[i], mAddr[i], mDone[i], mErr[i], 16'(mCnt[i])}) begin
      errors++;
      $display("FAIL model_%s t=%0t: got Instr=%h V=%b FA=%h Done=%b Err=%b Cnt=%h, expected Instr=%h V=%b FA=%h Done=%b Err=%b Cnt=%h",
               nm, $time, ins, v, a, d, e, c,
               mInstr[i], mValid[i], mAddr[i], mDone[i], mErr[i], 16'(mCnt[i]));
    end
  endtask

  // Every cycle once reset has been applied, both instances must match the model.
  always @(negedge Clk) begin
    if (armed) begin
      cmpDut("aw10", 0, instr0, valid0, fa0, done0, err0, cnt0);
      cmpDut("aw8", 1, instr8, valid8, fa8, done8, err8, cnt8);
    end
  end

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(negedge Clk);
  endtask

  logic [9:0] ldA [5];
  logic [8:0] ldD [5];
  logic [8:0] expI [4];

  initial begin
    ldA[0] = 10'h100; ldD[0] = 9'h05A;
    ldA[1] = 10'h000; ldD[1] = 9'h011;
    ldA[2] = 10'h001; ldD[2] = 9'h022;
    ldA[3] = 10'h002; ldD[3] = 9'h033;
    ldA[4] = 10'h003; ldD[4] = 9'h1FF;
    expI[0] = 9'h011; expI[1] = 9'h022; expI[2] = 9'h033; expI[3] = 9'h1FF;

    Reset = 1; Start = 0; Stall = 0; Flush = 0; LoadEn = 0;
    ProgCtr = 0; LoadAddr = 0; LoadData = 0;
    step(); step();
    armed = 1;
    chk("reset_instr", 32'(instr0), 32'h0);
    chk("reset_valid", 32'(valid0), 32'h0);
    chk("reset_done", 32'(done0), 32'h0);
    chk("reset_cnt", 32'(cnt0), 32'h0);
    chk("reset_err8", 32'(err8), 32'h0);

    // Preload; address 0x100 aliases to word 0 in the 256-word build and is then overwritten.
    Reset = 0; Flush = 1;
    for (int k = 0; k < 5; k++) begin
      LoadEn = 1; LoadAddr = ldA[k]; LoadData = ldD[k];
      step();
    end
    LoadEn = 0; Flush = 0;
    chk("idle_valid", 32'(valid0), 32'h0);

    Start = 1; step(); Start = 0;
    chk("start_no_fetch_valid", 32'(valid0), 32'h0);

    for (int k = 0; k < 4; k++) begin
      ProgCtr = 10'(k); step();
      chk("run_instr", 32'(instr0), 32'(expI[k]));
      chk("run_valid", 32'(valid0), 32'h1);
      chk("run_faddr", 32'(fa0), 32'(k));
      chk("run_instr8", 32'(instr8), 32'(expI[k]));
    end
    chk("halt_done", 32'(done0), 32'h1);
    chk("halt_cnt", 32'(cnt0), 32'd4);
    step();
    chk("done_valid", 32'(valid0), 32'h0);
    chk("done_instr", 32'(instr0), 32'h1FF);
    chk("done_faddr", 32'(fa0), 32'h3);

    // Restart from DONE on a Start rising edge.
    Start = 1; step(); Start = 0;
    chk("restart_done", 32'(done0), 32'h0);
    chk("restart_cnt_kept", 32'(cnt0), 32'd4);

    // Stall holds, Flush beats Stall.
    ProgCtr = 0; step();
    chk("pre_stall_instr", 32'(instr0), 32'h011);
    ProgCtr = 1; Stall = 1; step();
    chk("stall_instr", 32'(instr0), 32'h011);
    chk("stall_faddr", 32'(fa0), 32'h0);
    chk("stall_cnt", 32'(cnt0), 32'd5);
    ProgCtr = 2; Flush = 1; step();
    chk("flush_instr", 32'(instr0), 32'h0);
    chk("flush_valid", 32'(valid0), 32'h0);
    chk("flush_faddr", 32'(fa0), 32'h2);
    chk("flush_cnt", 32'(cnt0), 32'd5);
    Flush = 0; Stall = 0;

    // Load attempts while running are ignored.
    LoadEn = 1; LoadAddr = 0; LoadData = 9'h0AA; ProgCtr = 0; step();
    LoadEn = 0; step();
    chk("ignored_load", 32'(instr0), 32'h011);
    chk("ignored_load_cnt", 32'(cnt0), 32'd7);

    // Out-of-range fetch only in the 256-word build.
    ProgCtr = 10'h100; step();
    chk("oor_full_instr", 32'(instr0), 32'h05A);
    chk("oor_full_err", 32'(err0), 32'h0);
    chk("oor_instr8", 32'(instr8), 32'h0);
    chk("oor_valid8", 32'(valid8), 32'h1);
    chk("oor_err8", 32'(err8), 32'h1);
    chk("oor_cnt8", 32'(cnt8), 32'd8);
    ProgCtr = 1; step();
    chk("oor_back_instr8", 32'(instr8), 32'h022);
    chk("oor_sticky_err8", 32'(err8), 32'h1);

    // Start held high through HALT does not restart; Flush in DONE ignored.
    ProgCtr = 3; Start = 1; step();
    chk("halt2_done", 32'(done0), 32'h1);
    Flush = 1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("held_start_done", 32'(done0), 32'h1);
      chk("held_start_instr", 32'(instr0), 32'h1FF);
    end
    Flush = 0; Start = 0; step();
    Start = 1; step(); Start = 0;
    chk("rise_restart_done", 32'(done0), 32'h0);

    // Mid-run reset; memory survives.
    ProgCtr = 0; step();
    Reset = 1; step(); Reset = 0;
    chk("midrst_instr", 32'(instr0), 32'h0);
    chk("midrst_valid", 32'(valid0), 32'h0);
    chk("midrst_done", 32'(done0), 32'h0);
    chk("midrst_cnt", 32'(cnt0), 32'h0);
    chk("midrst_err8", 32'(err8), 32'h0);
    Start = 1; step(); Start = 0;
    ProgCtr = 3; step();
    chk("mem_kept_instr", 32'(instr0), 32'h1FF);
    chk("mem_kept_done", 32'(done0), 32'h1);

    // Counter saturation.
    Reset = 1; step(); Reset = 0;
    Start = 1; step(); Start = 0;
    ProgCtr = 0;
    repeat (65535) step();
    chk("sat_reach", 32'(cnt0), 32'hFFFF);
    step();
    chk("sat_hold", 32'(cnt0), 32'hFFFF);
    chk("sat_hold8", 32'(cnt8), 32'hFFFF);
    chk("sat_valid", 32'(valid0), 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
